// File: rtl/pipelined_addsub_if.sv
// Operand/result bundle for pipelined_addsub: valid/ready handshakes on the
// operand side (in_*) and the result side (out_*).
interface pipelined_addsub_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero, negative
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero, negative
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: each stage resolves WIDTH/STAGES
// result bits, with skewed operand/sum registers and per-stage valid/ready.
module pipelined_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              reset,
    pipelined_addsub_if.slave intf
);
    localparam int C = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    // Subtraction is a + ~b + ~cin, so a borrow-in removes the implicit +1.
    assign w_b_eff = intf.sub ? ~intf.b   : intf.b;
    assign w_c0    = intf.sub ? ~intf.cin : intf.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = WIDTH - k * C;
        localparam int SW = (k + 1) * C;

        logic [IW-1:0] w_a_in;
        logic [IW-1:0] w_b_in;
        logic          w_c_in;
        logic          w_valid_in;
        logic          w_ready;
        logic          w_ready_next;
        logic [C:0]    w_add;
        logic [SW-1:0] w_sum_next;

        logic          r_valid;
        logic          r_carry;
        logic [SW-1:0] r_sum;

        if (k == 0) begin : g_src
            assign w_a_in     = intf.a;
            assign w_b_in     = w_b_eff;
            assign w_c_in     = w_c0;
            assign w_valid_in = intf.in_valid;
            assign w_sum_next = w_add[C-1:0];
        end else begin : g_src
            assign w_a_in     = g_stage[k-1].g_ops.r_a;
            assign w_b_in     = g_stage[k-1].g_ops.r_b;
            assign w_c_in     = g_stage[k-1].r_carry;
            assign w_valid_in = g_stage[k-1].r_valid;
            assign w_sum_next = {w_add[C-1:0], g_stage[k-1].r_sum};
        end

        if (k == STAGES - 1) begin : g_down
            assign w_ready_next = intf.out_ready;
        end else begin : g_down
            assign w_ready_next = g_stage[k+1].w_ready;
        end

        // An empty stage always loads, so bubbles collapse under a downstream stall.
        assign w_ready = ~r_valid | w_ready_next;
        assign w_add   = {1'b0, w_a_in[C-1:0]} + {1'b0, w_b_in[C-1:0]} + {{C{1'b0}}, w_c_in};

        // NOTE: state registers use non-blocking assignments so every stage
        // samples its neighbour's pre-edge value and the pipeline shifts as one.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (w_ready) begin
                r_valid <= w_valid_in;
                if (w_valid_in) begin
                    r_carry <= w_add[C];
                    r_sum   <= w_sum_next;
                end
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [IW-C-1:0] r_a;
            logic [IW-C-1:0] r_b;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_ready && w_valid_in) begin
                    r_a <= w_a_in[IW-1:C];
                    r_b <= w_b_in[IW-1:C];
                end
            end
        end else begin : g_flags
            logic r_overflow;
            logic r_zero;

            // Signed overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_overflow <= 1'b0;
                    r_zero     <= 1'b0;
                end else if (w_ready && w_valid_in) begin
                    r_overflow <= w_a_in[C-1] ^ w_b_in[C-1] ^ w_add[C-1] ^ w_add[C];
                    r_zero     <= (w_sum_next == '0);
                end
            end
        end
    end

    assign intf.in_ready  = g_stage[0].w_ready;
    assign intf.out_valid = g_stage[STAGES-1].r_valid;
    assign intf.sum       = g_stage[STAGES-1].r_sum;
    assign intf.cout      = g_stage[STAGES-1].r_carry;
    assign intf.overflow  = g_stage[STAGES-1].g_flags.r_overflow;
    assign intf.zero      = g_stage[STAGES-1].g_flags.r_zero;
    assign intf.negative  = g_stage[STAGES-1].r_sum[WIDTH-1];
endmodule

// File: tb/tb_pipelined_addsub.sv
// Testbench for pipelined_addsub: 64/4 directed vectors, backpressure stream and
// reset mid-stream, plus WIDTH=8 instances with STAGES=1,2,4,8.
module tb_pipelined_addsub;
    localparam int W      = 64;
    localparam int S      = 4;
    localparam int NEXH   = 65536;
    localparam int NRND   = 256;
    localparam int NSWEEP = NEXH + NRND;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } vec_t;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic sweep_rst = 1'b1;
    int   n_checks  = 0;
    int   n_pass    = 0;

    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(W)) mif ();

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk   (clk),
        .reset (reset),
        .intf  (mif)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Full-width reference: one wide add, overflow from operand/result sign bits.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub, input int w);
        logic [63:0] mask;
        logic [63:0] beff;
        logic        c0;
        logic [64:0] full;
        res_t        r;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        beff   = (sub ? ~b : b) & mask;
        c0     = sub ? ~cin : cin;
        full   = {1'b0, a & mask} + {1'b0, beff} + {64'd0, c0};
        r.sum  = full[63:0] & mask;
        r.cout = full[w];
        r.ovf  = (a[w-1] == beff[w-1]) && (r.sum[w-1] != a[w-1]);
        r.zero = (r.sum == 64'd0);
        r.neg  = r.sum[w-1];
        return r;
    endfunction

    task automatic run_op(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        mif.out_ready = 1'b1;
        mif.in_valid  = 1'b1;
        mif.a         = v.a;
        mif.b         = v.b;
        mif.cin       = v.cin;
        mif.sub       = v.sub;
        #1 check($sformatf("vec%0d in_ready", idx), mif.in_ready, 1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        mif.in_valid = 1'b0;
        while (!mif.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check($sformatf("vec%0d latency", idx), lat, S);
        check($sformatf("vec%0d sum", idx), mif.sum, v.sum);
        check($sformatf("vec%0d cout", idx), mif.cout, v.cout);
        check($sformatf("vec%0d overflow", idx), mif.overflow, v.ovf);
        check($sformatf("vec%0d zero", idx), mif.zero, v.zero);
        check($sformatf("vec%0d negative", idx), mif.negative, v.neg);
    endtask

    initial begin : p_main
        vec_t        tbl[10];
        logic [63:0] sa[16];
        logic [63:0] sb[16];
        logic        scin[16];
        logic        ssub[16];
        res_t        q[$];
        res_t        e;
        int          sent, got, cyc;
        logic        stale;

        tbl[0] = '{64'h2de3aab587bb3212, 64'h432ab543ede98790, 1'b0, 1'b0, 64'h710e5ff975a4b9a2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{64'h2de3aab587bb3212, 64'h432ab543ede98790, 1'b1, 1'b0, 64'h710e5ff975a4b9a3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{64'h7fffffffffffffff, 64'h1, 1'b0, 1'b0, 64'h8000000000000000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{64'h8000000000000000, 64'h8000000000000000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{64'h5, 64'h5, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{64'h0, 64'h1, 1'b0, 1'b1, 64'hffffffffffffffff, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{64'ha, 64'h3, 1'b1, 1'b1, 64'h6, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{64'h8000000000000000, 64'h1, 1'b0, 1'b1, 64'h7fffffffffffffff, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{64'hffffffffffffffff, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{64'h0000ffff0000ffff, 64'h1, 1'b0, 1'b0, 64'h0000ffff00010000, 1'b0, 1'b0, 1'b0, 1'b0};

        mif.in_valid  = 1'b0;
        mif.out_ready = 1'b0;
        mif.a         = '0;
        mif.b         = '0;
        mif.cin       = 1'b0;
        mif.sub       = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", mif.out_valid, 0);
        check("reset in_ready", mif.in_ready, 1);
        check("reset sum", mif.sum, 0);
        check("reset flags", {mif.cout, mif.overflow, mif.zero, mif.negative}, 4'b0000);
        reset     = 1'b0;
        sweep_rst = 1'b0;

        for (int i = 0; i < 10; i++) run_op(tbl[i], i);

        // Backpressure stream: in_valid held high, out_ready random.
        for (int i = 0; i < 16; i++) begin
            sa[i]   = {$urandom, $urandom};
            sb[i]   = {$urandom, $urandom};
            scin[i] = 1'($urandom_range(0, 1));
            ssub[i] = 1'($urandom_range(0, 1));
        end
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 16 && cyc < 400) begin
            @(negedge clk);
            mif.out_ready = 1'($urandom_range(0, 1));
            if (sent < 16) begin
                mif.in_valid = 1'b1;
                mif.a        = sa[sent];
                mif.b        = sb[sent];
                mif.cin      = scin[sent];
                mif.sub      = ssub[sent];
            end else begin
                mif.in_valid = 1'b0;
            end
            #1;
            check("stream in_ready", mif.in_ready, !(q.size() == S && !mif.out_ready));
            if (mif.out_valid && mif.out_ready) begin
                if (q.size() == 0) begin
                    check("stream spurious out_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("stream%0d sum", got), mif.sum, e.sum);
                    check($sformatf("stream%0d flags", got),
                          {mif.cout, mif.overflow, mif.zero, mif.negative},
                          {e.cout, e.ovf, e.zero, e.neg});
                    got++;
                end
            end
            if (mif.in_valid && mif.in_ready) begin
                q.push_back(model(sa[sent], sb[sent], scin[sent], ssub[sent], W));
                sent++;
            end
            cyc++;
        end
        check("stream delivered", got, 16);
        mif.in_valid  = 1'b0;
        mif.out_ready = 1'b1;
        repeat (S + 1) @(negedge clk);

        // Reset with three operations in flight and the output stalled.
        mif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mif.in_valid = 1'b1;
            mif.a        = tbl[i].a;
            mif.b        = tbl[i].b;
            mif.cin      = tbl[i].cin;
            mif.sub      = tbl[i].sub;
            @(posedge clk);
            @(negedge clk);
        end
        mif.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre-reset out_valid", mif.out_valid, 1);
        check("pre-reset sum", mif.sum, tbl[0].sum);
        #2 reset = 1'b1;
        #1;
        check("async reset out_valid", mif.out_valid, 0);
        check("async reset sum", mif.sum, 0);
        check("async reset flags", {mif.cout, mif.overflow, mif.zero, mif.negative}, 4'b0000);
        check("async reset in_ready", mif.in_ready, 1);
        @(negedge clk);
        reset         = 1'b0;
        mif.out_ready = 1'b1;
        stale         = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mif.out_valid) stale = 1'b1;
        end
        check("post-reset stale out_valid", stale, 0);
        run_op(tbl[9], 90);

        for (int c = 0; c < 80000 && !(g_sweep[0].done && g_sweep[1].done &&
                                       g_sweep[2].done && g_sweep[3].done); c++) begin
            @(posedge clk);
        end
        check("sweep completed",
              {g_sweep[3].done, g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}, 4'hf);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // WIDTH=8 instances: exhaustive a/b at full throughput, then random backpressure.
    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int SS = 1 << g;
        logic done = 1'b0;

        pipelined_addsub_if #(.WIDTH(8)) sif ();

        pipelined_addsub #(.WIDTH(8), .STAGES(SS)) u_dut (
            .clk   (clk),
            .reset (sweep_rst),
            .intf  (sif)
        );

        initial begin : p_sweep
            res_t        q[$];
            res_t        e;
            logic [17:0] rv[NRND];
            logic [15:0] n;
            logic [7:0]  ca, cb;
            logic        ccin, csub;
            int          sent, got, cyc, lat;

            sif.in_valid  = 1'b0;
            sif.out_ready = 1'b0;
            sif.a         = '0;
            sif.b         = '0;
            sif.cin       = 1'b0;
            sif.sub       = 1'b0;
            for (int i = 0; i < NRND; i++) rv[i] = 18'($urandom);
            wait (!sweep_rst);

            @(negedge clk);
            sif.out_ready = 1'b1;
            sif.in_valid  = 1'b1;
            sif.a         = 8'h7f;
            sif.b         = 8'h01;
            @(posedge clk);
            lat = 1;
            @(negedge clk);
            sif.in_valid = 1'b0;
            while (!sif.out_valid && lat < 20) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            check($sformatf("sweep S=%0d latency", SS), lat, SS);
            check($sformatf("sweep S=%0d 7f+1", SS),
                  {sif.sum, sif.cout, sif.overflow, sif.zero, sif.negative},
                  {8'h80, 1'b0, 1'b1, 1'b0, 1'b1});

            sent = 0;
            got  = 0;
            cyc  = 0;
            while (got < NSWEEP && cyc < 70000) begin
                @(negedge clk);
                if (sent < NEXH) begin
                    n    = 16'(sent);
                    ca   = n[15:8];
                    cb   = n[7:0];
                    ccin = n[0] ^ n[8];
                    csub = n[1] ^ n[9];
                    sif.out_ready = 1'b1;
                end else begin
                    ca   = rv[(sent - NEXH) % NRND][7:0];
                    cb   = rv[(sent - NEXH) % NRND][15:8];
                    ccin = rv[(sent - NEXH) % NRND][16];
                    csub = rv[(sent - NEXH) % NRND][17];
                    sif.out_ready = 1'($urandom_range(0, 1));
                end
                sif.in_valid = (sent < NSWEEP);
                sif.a        = ca;
                sif.b        = cb;
                sif.cin      = ccin;
                sif.sub      = csub;
                #1;
                check($sformatf("sweep S=%0d in_ready", SS), sif.in_ready,
                      !(q.size() == SS && !sif.out_ready));
                if (sif.out_valid && sif.out_ready) begin
                    if (q.size() == 0) begin
                        check($sformatf("sweep S=%0d spurious out_valid", SS), 1, 0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("sweep S=%0d result%0d", SS, got),
                              {sif.sum, sif.cout, sif.overflow, sif.zero, sif.negative},
                              {e.sum[7:0], e.cout, e.ovf, e.zero, e.neg});
                        got++;
                    end
                end
                if (sif.in_valid && sif.in_ready) begin
                    q.push_back(model({56'd0, ca}, {56'd0, cb}, ccin, csub, 8));
                    sent++;
                end
                cyc++;
            end
            sif.in_valid = 1'b0;
            check($sformatf("sweep S=%0d delivered", SS), got, NSWEEP);
            done = 1'b1;
        end
    end
endmodule
